// File: rtl/bus_arbiter_if.sv
// Request/ack handshake for the two masters plus the shared data_bus signals.
// The arbiter connects through the slave modport; master-side logic uses the master modport.
interface bus_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_rdata;
  logic                  m0_err;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_rdata;
  logic                  m1_err;

  logic                  bus_rw;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_write;
  logic [DATA_WIDTH-1:0] bus_read;
  logic                  bus_exception;
  logic                  busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata, m1_err,
    output bus_rw, bus_addr, bus_write,
    input  bus_read, bus_exception,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata, m1_err,
    input  bus_rw, bus_addr, bus_write,
    output bus_read, bus_exception,
    input  busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-master arbiter for the shared data_bus: grants one requester, holds the
// bus for BUS_LATENCY cycles, captures read data/exception and returns a one-cycle ack.
module bus_arbiter #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int BUS_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_if.slave   arb
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(BUS_LATENCY - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  grant_id_q, grant_id_d;
  logic                  last_grant_q, last_grant_d;
  logic                  busy_q, busy_d;

  logic                  bus_rw_q, bus_rw_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_write_q, bus_write_d;

  logic                  m0_ack_q, m0_ack_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic                  m0_err_q, m0_err_d;
  logic                  m1_ack_q, m1_ack_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  m1_err_q, m1_err_d;

  logic                  win_valid;
  logic                  win_id;

  // Under contention the master that was not served last wins.
  always_comb begin
    win_valid = arb.m0_req | arb.m1_req;
    if (arb.m0_req && arb.m1_req) win_id = ~last_grant_q;
    else                          win_id = arb.m1_req;
  end

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    bus_rw_d     = bus_rw_q;
    bus_addr_d   = bus_addr_q;
    bus_write_d  = bus_write_q;
    m0_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m0_err_d     = m0_err_q;
    m1_ack_d     = 1'b0;
    m1_rdata_d   = m1_rdata_q;
    m1_err_d     = m1_err_q;

    case (state_q)
      IDLE: begin
        bus_rw_d = 1'b0;
        if (win_valid) begin
          grant_id_d  = win_id;
          cnt_d       = CNT_LOAD;
          state_d     = ACCESS;
          bus_rw_d    = win_id ? arb.m1_we    : arb.m0_we;
          bus_addr_d  = win_id ? arb.m1_addr  : arb.m0_addr;
          bus_write_d = win_id ? arb.m1_wdata : arb.m0_wdata;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          bus_rw_d     = 1'b0;
          last_grant_d = grant_id_q;
          state_d      = DONE;
          if (grant_id_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = arb.bus_read;
            m1_err_d   = arb.bus_exception;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = arb.bus_read;
            m0_err_d   = arb.bus_exception;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: datapath registers are reset too, because every output is required to read 0 after reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      bus_rw_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_write_q  <= '0;
      m0_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m0_err_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m1_rdata_q   <= '0;
      m1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      bus_rw_q     <= bus_rw_d;
      bus_addr_q   <= bus_addr_d;
      bus_write_q  <= bus_write_d;
      m0_ack_q     <= m0_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m0_err_q     <= m0_err_d;
      m1_ack_q     <= m1_ack_d;
      m1_rdata_q   <= m1_rdata_d;
      m1_err_q     <= m1_err_d;
    end
  end

  assign arb.bus_rw    = bus_rw_q;
  assign arb.bus_addr  = bus_addr_q;
  assign arb.bus_write = bus_write_q;
  assign arb.m0_ack    = m0_ack_q;
  assign arb.m0_rdata  = m0_rdata_q;
  assign arb.m0_err    = m0_err_q;
  assign arb.m1_ack    = m1_ack_q;
  assign arb.m1_rdata  = m1_rdata_q;
  assign arb.m1_err    = m1_err_q;
  assign arb.busy      = busy_q;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared data_bus (rw, addr, read, write, exception).
- Port 0 is the zipocpu load/store path. Port 1 is the memory sweep/LED-dump master.
- The block selects one requester, drives the bus for a fixed number of cycles, captures read data and exception status, and returns a one-cycle ack.
- Round-robin priority prevents either master from starving the other.

Parameters:
- ADDR_WIDTH, 64, width of address on both masters and the bus.
- DATA_WIDTH, 64, width of read/write data.
- BUS_LATENCY, 1, cycles the bus must be held before read/exception are valid (1..15).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 request; held high until m0_ack.
- m0_we  in  1  master 0 write enable (1 = write).
- m0_addr  in  ADDR_WIDTH  master 0 address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_WIDTH  read data; valid while m0_ack is high.
- m0_err  out  1  bus exception flag; valid while m0_ack is high.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err: identical set for master 1.
- bus_rw  out  1  bus write flag.
- bus_addr  out  ADDR_WIDTH  bus address.
- bus_write  out  DATA_WIDTH  bus write data.
- bus_read  in  DATA_WIDTH  bus read data.
- bus_exception  in  1  bus exception for the current address.
- busy  out  1  high while a transaction is in progress (any state other than IDLE).

Behaviour:
- Reset (synchronous, active-high, rst sampled on posedge clk):
  - State goes to IDLE and last_grant to 1, so master 0 wins the first contention.
  - All outputs are registered and reset to 0.
- Reset mid-transaction aborts it: no ack is issued and bus_rw drops to 0 on the next edge.
- IDLE:
  - With no req, bus_rw = 0 and bus_addr/bus_write hold their last values.
  - If exactly one req is high, that master wins.
  - If both are high, the master other than last_grant wins.
  - On the grant edge: latch the winner's we/addr/wdata into bus_rw/bus_addr/bus_write; load the latency counter with BUS_LATENCY-1; set grant_id; go to ACCESS.
- ACCESS:
  - Bus outputs are held constant.
  - The counter decrements each cycle.
  - When the counter equals 0: capture bus_read and bus_exception into the granted master's rdata/err, assert its ack, force bus_rw to 0, set last_grant = grant_id, and go to DONE.
- DONE:
  - Lasts one cycle, with ack high for exactly this cycle.
  - Unconditionally returns to IDLE; no arbitration occurs here.
  - A master still holding req in the following IDLE cycle is treated as a new request.
- Latency:
  - Grant edge to ack high is BUS_LATENCY+1 cycles.
  - Back-to-back throughput is one transaction per BUS_LATENCY+2 cycles.
- Bus rules:
  - bus_rw is high only during ACCESS of a write transaction.
  - bus_write is don't-care for reads but still driven from the latched wdata.
- Request rules:
  - Req dropped before ack is a protocol violation. The transaction still completes and ack still pulses.
  - A req edge arriving during ACCESS/DONE is queued implicitly: it is seen in the next IDLE.
- Outputs to the non-granted master:
  - Its ack stays 0.
  - Its rdata/err hold their previous values.
- Exceptions:
  - Exceptions are reported, never retried.
  - Writes with bus_exception = 1 still complete with err = 1.
- Addresses pass through unmodified: no wrap or bounds checking; the bus decodes ranges.

Test Plan:
- Single read: after reset, m0_req=1, m0_we=0, m0_addr=0x10, bus_read=0xA5 -> bus_addr=0x10 and bus_rw=0 one cycle after the grant; m0_ack pulses exactly once at grant+2 (BUS_LATENCY=1) with m0_rdata=0xA5, m0_err=0; m1_ack stays 0.
- Write: m1_req=1, m1_we=1, m1_addr=0x20, m1_wdata=0x41 -> bus_rw=1, bus_write=0x41 for exactly BUS_LATENCY cycles, then 0; m1_ack pulses once.
- Contention fairness: hold m0_req and m1_req high continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; each ack is a single cycle; the gap between acks is BUS_LATENCY+2.
- Exception: m0 reads an address with bus_exception=1 -> m0_ack with m0_err=1. The next read without exception -> m0_err=0.
- Latency parameter: BUS_LATENCY=4 -> bus outputs stable for 4 cycles and ack at grant+5; changing bus_read before the final ACCESS cycle does not affect the captured rdata.
- Reset mid-op: assert rst during ACCESS of a write -> the next edge gives bus_rw=0, busy=0, no ack. After release, simultaneous requests grant master 0 first.
